// File: rtl/aes_pkg.sv
// Shared AES constants, the 128-bit block type and the word packer FSM states.
package aes_pkg;

    localparam int unsigned AES_BLK_W         = 128;
    localparam int unsigned AES_WORD_W        = 32;
    localparam int unsigned AES_WORDS_PER_BLK = 4;

    typedef logic [AES_BLK_W-1:0] aes_block_t;

    typedef enum logic {
        FILL,
        HOLD
    } packer_state_t;

endpackage

// File: rtl/aes_word_packer_if.sv
// Word-stream input and block-stream output of the AES word packer.
// The packer uses the slave view; the environment uses the master view.
interface aes_word_packer_if;
    import aes_pkg::*;

    logic [AES_WORD_W-1:0] s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;
    aes_block_t            m_block;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_block, m_valid, m_last
    );

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_block, m_valid, m_last
    );

endinterface

// File: rtl/aes_word_packer.sv
// Packs four 32-bit ciphertext words into one 128-bit block, first word in the MSBs.
// Define AES_PACKER_BYTE_SWAP_EN to byte-reverse each word for little-endian sources.
module aes_word_packer
    import aes_pkg::*;
#(
    parameter int unsigned WORD_W        = AES_WORD_W,
    parameter int unsigned WORDS_PER_BLK = AES_WORDS_PER_BLK
) (
    input  logic                     clk,
    input  logic                     rst_n,
    aes_word_packer_if.slave         bus,
    output logic                     err_partial
);

    localparam logic [1:0] LastSlot = 2'(WORDS_PER_BLK - 1);

    packer_state_t     state_q;
    aes_block_t        asm_q;
    aes_block_t        out_q;
    aes_block_t        asm_merged;
    logic [1:0]        cnt_q;
    logic              asm_last_q;
    logic              out_v_q;
    logic              out_last_q;
    logic              s_ready_q;
    logic              err_q;
    logic [WORD_W-1:0] word_in;
    logic              accept;
    logic              complete;
    logic              out_free;

`ifdef AES_PACKER_BYTE_SWAP_EN
    function automatic logic [WORD_W-1:0] byte_swap(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(WORD_W / 8); i++) begin
            r[8*i +: 8] = w[WORD_W-8-8*i +: 8];
        end
        return r;
    endfunction
    assign word_in = byte_swap(bus.s_data);
`else
    assign word_in = bus.s_data;
`endif

    // Slot cnt of the block, counting down from the MSB word.
    always_comb begin
        asm_merged = asm_q;
        asm_merged[AES_BLK_W - WORD_W * (int'(cnt_q) + 1) +: WORD_W] = word_in;
    end

    assign accept   = bus.s_valid && s_ready_q;
    assign complete = accept && ((cnt_q == LastSlot) || bus.s_last);
    assign out_free = !out_v_q || bus.m_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FILL;
            asm_q      <= '0;
            out_q      <= '0;
            cnt_q      <= '0;
            asm_last_q <= 1'b0;
            out_v_q    <= 1'b0;
            out_last_q <= 1'b0;
            s_ready_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (out_v_q && bus.m_ready) begin
                out_v_q <= 1'b0;
            end
            case (state_q)
                FILL: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        if (bus.s_last && (cnt_q != LastSlot)) begin
                            err_q <= 1'b1;
                        end
                        if (!complete) begin
                            asm_q <= asm_merged;
                            cnt_q <= cnt_q + 2'd1;
                        end else if (out_free) begin
                            out_q      <= asm_merged;
                            out_v_q    <= 1'b1;
                            out_last_q <= bus.s_last;
                            asm_q      <= '0;
                            cnt_q      <= '0;
                        end else begin
                            // Output still occupied: park the finished block and stall.
                            asm_q      <= asm_merged;
                            asm_last_q <= bus.s_last;
                            cnt_q      <= '0;
                            state_q    <= HOLD;
                            s_ready_q  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (out_free) begin
                        out_q      <= asm_q;
                        out_v_q    <= 1'b1;
                        out_last_q <= asm_last_q;
                        asm_q      <= '0;
                        state_q    <= FILL;
                        s_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.m_block = out_q;
    assign bus.m_valid = out_v_q;
    assign bus.m_last  = out_last_q;
    assign err_partial = err_q;

endmodule

// File: tb/tb_aes_word_packer.sv
// Self-checking bench for aes_word_packer: directed cases plus a randomized run
// scored against a queue-based block model.
module tb_aes_word_packer;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_partial;

    always #5 clk = ~clk;

    aes_word_packer_if bus ();

    aes_word_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .err_partial (err_partial)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]  in_w[$];
    bit           in_l[$];
    logic [127:0] obs_blk[$];
    bit           obs_last[$];
    logic [127:0] exp_blk[$];
    bit           exp_last[$];

    logic         hold_prev = 1'b0;
    logic [127:0] prev_blk  = '0;
    logic         prev_last = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] swap_w(input logic [31:0] w);
`ifdef AES_PACKER_BYTE_SWAP_EN
        return {<<8{w}};
`else
        return w;
`endif
    endfunction

    // Pre-distorts directed words so the packed block is the same in either build.
    function automatic logic [31:0] prep(input logic [31:0] w);
        return swap_w(w);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit last);
        bit got;
        got = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        bus.s_last  = last;
        for (int n = 0; n < 50; n++) begin
            got = bus.s_ready;
            step();
            if (got) break;
        end
        chk("send_accept", 128'(got), 128'(1));
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic clear_queues();
        in_w.delete();
        in_l.delete();
        obs_blk.delete();
        obs_last.delete();
    endtask

    // Reference: group accepted words by four or by s_last, zero-padding the rest.
    task automatic build_model();
        logic [127:0] acc;
        int n;
        acc = '0;
        n = 0;
        exp_blk.delete();
        exp_last.delete();
        foreach (in_w[i]) begin
            acc = acc | (128'(swap_w(in_w[i])) << (32 * (3 - n)));
            n++;
            if (n == 4 || in_l[i]) begin
                exp_blk.push_back(acc);
                exp_last.push_back(in_l[i]);
                acc = '0;
                n = 0;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        int k;
        build_model();
        chk({tag, "_count"}, 128'(obs_blk.size()), 128'(exp_blk.size()));
        k = (obs_blk.size() < exp_blk.size()) ? obs_blk.size() : exp_blk.size();
        for (int i = 0; i < k; i++) begin
            chk({tag, "_block"}, obs_blk[i], exp_blk[i]);
            chk({tag, "_last"}, 128'(obs_last[i]), 128'(exp_last[i]));
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev <= 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", 128'(bus.m_valid), 128'(1));
                chk("hold_block", bus.m_block, prev_blk);
                chk("hold_last", 128'(bus.m_last), 128'(prev_last));
            end
            hold_prev <= bus.m_valid && !bus.m_ready;
            prev_blk  <= bus.m_block;
            prev_last <= bus.m_last;
            if (bus.s_valid && bus.s_ready) begin
                in_w.push_back(bus.s_data);
                in_l.push_back(bus.s_last);
            end
            if (bus.m_valid && bus.m_ready) begin
                obs_blk.push_back(bus.m_block);
                obs_last.push_back(bus.m_last);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]  kat[4];
        logic [31:0]  b2[4];
        logic [127:0] blk1;
        logic [127:0] blk2;
        logic [31:0]  top_word;
        int           low_cycles;

        kat  = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
        b2   = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
        blk1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        blk2 = 128'h00112233445566778899aabbccddeeff;

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;

        // Reset values.
        step();
        step();
        chk("rst_s_ready", 128'(bus.s_ready), 128'(0));
        chk("rst_m_valid", 128'(bus.m_valid), 128'(0));
        chk("rst_m_last", 128'(bus.m_last), 128'(0));
        chk("rst_m_block", bus.m_block, 128'(0));
        chk("rst_err", 128'(err_partial), 128'(0));
        rst_n = 1'b1;
        step();
        chk("post_rst_s_ready", 128'(bus.s_ready), 128'(1));

        // Single block, m_valid visible the cycle after the fourth word.
        for (int i = 0; i < 4; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = prep(kat[i]);
            step();
        end
        bus.s_valid = 1'b0;
        chk("single_valid", 128'(bus.m_valid), 128'(1));
        chk("single_block", bus.m_block, blk1);
        chk("single_last", 128'(bus.m_last), 128'(0));
        step();
        chk("single_valid_drop", 128'(bus.m_valid), 128'(0));

        // Backpressure: two blocks in while the output is stalled.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(prep(kat[i]), 1'b0);
        for (int i = 0; i < 4; i++) send_word(prep(b2[i]), 1'b0);
        chk("bp_hold_s_ready", 128'(bus.s_ready), 128'(0));
        chk("bp_blk1", bus.m_block, blk1);
        step();
        step();
        chk("bp_blk1_stable", bus.m_block, blk1);
        chk("bp_s_ready_still_low", 128'(bus.s_ready), 128'(0));
        bus.m_ready = 1'b1;
        step();
        chk("bp_blk2_valid", 128'(bus.m_valid), 128'(1));
        chk("bp_blk2", bus.m_block, blk2);
        chk("bp_resume_s_ready", 128'(bus.s_ready), 128'(1));
        step();
        chk("bp_drained", 128'(bus.m_valid), 128'(0));

        // Back-to-back: twelve words, never stalled.
        clear_queues();
        low_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = $urandom;
            if (!bus.s_ready) low_cycles++;
            step();
        end
        bus.s_valid = 1'b0;
        step();
        step();
        chk("b2b_no_stall", 128'(low_cycles), 128'(0));
        chk("b2b_three_blocks", 128'(obs_blk.size()), 128'(3));
        compare_model("b2b");

        // Partial block terminated by s_last.
        send_word(prep(32'h11111111), 1'b0);
        send_word(prep(32'h22222222), 1'b1);
        chk("part_valid", 128'(bus.m_valid), 128'(1));
        chk("part_block", bus.m_block, 128'h11111111222222220000000000000000);
        chk("part_last", 128'(bus.m_last), 128'(1));
        chk("part_err", 128'(err_partial), 128'(1));
        step();
        step();
        chk("part_err_sticky", 128'(err_partial), 128'(1));

        // Full block ending in s_last: m_last set, padding left clean.
        for (int i = 0; i < 4; i++) send_word(prep(b2[i]), i == 3);
        chk("full_last_block", bus.m_block, blk2);
        chk("full_last_flag", 128'(bus.m_last), 128'(1));
        chk("full_last_err_kept", 128'(err_partial), 128'(1));
        step();

        // Reset mid-block discards the partial words.
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b0);
        rst_n = 1'b0;
        step();
        chk("midrst_s_ready", 128'(bus.s_ready), 128'(0));
        chk("midrst_m_valid", 128'(bus.m_valid), 128'(0));
        rst_n = 1'b1;
        step();
        clear_queues();
        chk("midrst_err_clear", 128'(err_partial), 128'(0));
        for (int i = 0; i < 4; i++) send_word(prep(kat[i]), 1'b0);
        step();
        step();
        chk("midrst_one_block", 128'(obs_blk.size()), 128'(1));
        if (obs_blk.size() > 0) chk("midrst_block", obs_blk[0], blk1);
        chk("midrst_err_still_clear", 128'(err_partial), 128'(0));

        // Randomized traffic with random backpressure.
        clear_queues();
        for (int i = 0; i < 400; i++) begin
            bus.s_valid = ($urandom_range(0, 3) != 0);
            bus.s_data  = $urandom;
            bus.s_last  = ($urandom_range(0, 7) == 0);
            bus.m_ready = $urandom_range(0, 1) != 0;
            step();
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        send_word($urandom, 1'b1);
        for (int i = 0; i < 4; i++) step();
        chk("rand_out_idle", 128'(bus.m_valid), 128'(0));
        compare_model("rand");

`ifdef AES_PACKER_BYTE_SWAP_EN
        // Little-endian source word becomes the big-endian block MSB word.
        send_word(32'hd8e0c469, 1'b0);
        for (int i = 1; i < 4; i++) send_word($urandom, i == 3);
        top_word = bus.m_block[127:96];
        chk("swap_word0", 128'(top_word), 128'(32'h69c4e0d8));
`else
        top_word = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
